// File: rtl/mul_booth_pkg.sv
// Shared types and constants for the sequential radix-4 Booth multiplier.
// The digit select code is packed as {neg, two, zero}.
package mul_booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Booth digit select codes, packed as {neg, two, zero}
  localparam logic [2:0] ZERO = 3'b001;
  localparam logic [2:0] POS1 = 3'b000;
  localparam logic [2:0] POS2 = 3'b010;
  localparam logic [2:0] NEG1 = 3'b100;
  localparam logic [2:0] NEG2 = 3'b110;

  // Digits needed to cover a WIDTH+2 bit extended multiplier
  function automatic int booth_digits(input int width);
    return width / 2 + 1;
  endfunction

endpackage

// File: rtl/booth_r4_enc.sv
// Radix-4 Booth recoder: one multiplier triplet {y[2i+1], y[2i], y[2i-1]}
// to the select flags that drive the partial-product mux.
module booth_r4_enc
  import mul_booth_pkg::*;
(
  input  logic [2:0] triplet,
  output logic       neg,
  output logic       two,
  output logic       zero
);

  logic [2:0] sel;

  always_comb begin
    case (triplet)
      3'b000, 3'b111: sel = ZERO;
      3'b001, 3'b010: sel = POS1;
      3'b011:         sel = POS2;
      3'b100:         sel = NEG2;
      3'b101, 3'b110: sel = NEG1;
      default:        sel = ZERO;
    endcase
  end

  assign {neg, two, zero} = sel;

endmodule

// File: rtl/mul_booth_r4_seq.sv
// Sequential radix-4 Booth multiplier, one digit per cycle, with valid/ready
// handshakes, per-operation signed/unsigned mode and a pass-through tag.
module mul_booth_r4_seq
  import mul_booth_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  input  logic               is_signed,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] prod,
  output logic [TAG_W-1:0]   out_tag,
  output logic               busy
);

  localparam int N     = booth_digits(WIDTH);
  localparam int EW    = WIDTH + 2;
  localparam int ACC_W = 2 * WIDTH + 4;
  localparam int CNT_W = $clog2(N);

  state_t             state_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [ACC_W-1:0]   acc_reg;
  logic [ACC_W-1:0]   x_sh_reg;
  logic [EW:0]        y_sh_reg;
  logic               in_ready_reg;
  logic               out_valid_reg;
  logic               busy_reg;
  logic [2*WIDTH-1:0] prod_reg;
  logic [TAG_W-1:0]   out_tag_reg;

  logic [EW-1:0]      x_ext;
  logic [EW-1:0]      y_ext;
  logic               enc_neg;
  logic               enc_two;
  logic               enc_zero;
  logic [ACC_W-1:0]   pp_mag;
  logic [ACC_W-1:0]   pp;
  logic [ACC_W-1:0]   acc_next;

  // Two guard bits keep unsigned full-range operands and -(most negative) exact
  assign x_ext = is_signed ? {{2{x[WIDTH-1]}}, x} : {2'b00, x};
  assign y_ext = is_signed ? {{2{y[WIDTH-1]}}, y} : {2'b00, y};

  // Low three bits of the shifting multiplier are always the current triplet
  booth_r4_enc u_enc (
    .triplet (y_sh_reg[2:0]),
    .neg     (enc_neg),
    .two     (enc_two),
    .zero    (enc_zero)
  );

  // Multiplicand is pre-shifted by 2 each cycle, so no per-digit barrel shift;
  // negating in the full accumulator width is congruent to the narrow ~X+1.
  always_comb begin
    pp_mag = '0;
    if (!enc_zero) begin
      pp_mag = enc_two ? {x_sh_reg[ACC_W-2:0], 1'b0} : x_sh_reg;
    end
    pp       = enc_neg ? (~pp_mag + ACC_W'(1)) : pp_mag;
    acc_next = acc_reg + pp;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      acc_reg       <= '0;
      x_sh_reg      <= '0;
      y_sh_reg      <= '0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
      prod_reg      <= '0;
      out_tag_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            x_sh_reg     <= {{(ACC_W-EW){x_ext[EW-1]}}, x_ext};
            y_sh_reg     <= {y_ext, 1'b0};
            out_tag_reg  <= in_tag;
            acc_reg      <= '0;
            cnt_reg      <= '0;
            in_ready_reg <= 1'b0;
            busy_reg     <= 1'b1;
            state_reg    <= CALC;
          end
        end
        CALC: begin
          acc_reg  <= acc_next;
          x_sh_reg <= {x_sh_reg[ACC_W-3:0], 2'b00};
          y_sh_reg <= {{2{y_sh_reg[EW]}}, y_sh_reg[EW:2]};
          cnt_reg  <= cnt_reg + CNT_W'(1);
          if (cnt_reg == CNT_W'(N - 1)) begin
            prod_reg      <= acc_next[2*WIDTH-1:0];
            out_valid_reg <= 1'b1;
            state_reg     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            busy_reg      <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: begin
          out_valid_reg <= 1'b0;
          in_ready_reg  <= 1'b1;
          busy_reg      <= 1'b0;
          state_reg     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign busy      = busy_reg;
  assign prod      = prod_reg;
  assign out_tag   = out_tag_reg;

endmodule

// File: tb/tb_mul_booth_r4_seq.sv
// Directed bench for mul_booth_r4_seq: a WIDTH=32 and a WIDTH=8 instance
// driven on the falling edge and sampled on the falling edge.
module tb_mul_booth_r4_seq;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic        iv32 = 1'b0, s32 = 1'b0, or32 = 1'b0;
  logic        ir32, ov32, busy32;
  logic [31:0] x32 = '0, y32 = '0;
  logic [3:0]  it32 = '0, ot32;
  logic [63:0] p32;

  logic        iv8 = 1'b0, s8 = 1'b0, or8 = 1'b0;
  logic        ir8, ov8, busy8;
  logic [7:0]  x8 = '0, y8 = '0;
  logic [3:0]  it8 = '0, ot8;
  logic [15:0] p8;

  int n_vec = 0;
  int n_bad = 0;

  mul_booth_r4_seq #(.WIDTH(32), .TAG_W(4)) dut32 (
    .clk(clk), .reset(reset), .in_valid(iv32), .in_ready(ir32), .x(x32), .y(y32),
    .is_signed(s32), .in_tag(it32), .out_valid(ov32), .out_ready(or32),
    .prod(p32), .out_tag(ot32), .busy(busy32)
  );

  mul_booth_r4_seq #(.WIDTH(8), .TAG_W(4)) dut8 (
    .clk(clk), .reset(reset), .in_valid(iv8), .in_ready(ir8), .x(x8), .y(y8),
    .is_signed(s8), .in_tag(it8), .out_valid(ov8), .out_ready(or8),
    .prod(p8), .out_tag(ot8), .busy(busy8)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the accept edge
  task automatic send32(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input logic [3:0] t);
    int w = 0;
    while (!ir32 && w < 50) begin @(negedge clk); w++; end
    check("send32_ready", 64'(ir32), 64'd1);
    x32 = a; y32 = b; s32 = s; it32 = t; iv32 = 1'b1;
    @(negedge clk);
    iv32 = 1'b0;
  endtask

  task automatic wait_ov32(output int e);
    e = 0;
    while (!ov32 && e < 60) begin @(negedge clk); e++; end
  endtask

  task automatic recv32(input logic [63:0] exp, input logic [3:0] t, input string name);
    int e;
    wait_ov32(e);
    check({name, "_lat"}, 64'(e), 64'd17);
    check({name, "_prod"}, p32, exp);
    check({name, "_tag"}, 64'(ot32), 64'(t));
    or32 = 1'b1;
    @(negedge clk);
    or32 = 1'b0;
    check({name, "_ov_drop"}, 64'(ov32), 64'd0);
    $display("vec %s: x=0x%08h y=0x%08h s=%0d prod=0x%016h tag=%0h", name, x32, y32, s32, p32, ot32);
  endtask

  function automatic logic [15:0] model8(input logic [7:0] a, input logic [7:0] b, input logic s);
    logic [15:0] ea, eb;
    ea = s ? {{8{a[7]}}, a} : {8'h00, a};
    eb = s ? {{8{b[7]}}, b} : {8'h00, b};
    return ea * eb;
  endfunction

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic s,
                      input logic [3:0] t, input logic [15:0] exp, input int hold,
                      input string name);
    int w = 0;
    int e = 0;
    while (!ir8 && w < 30) begin @(negedge clk); w++; end
    check({name, "_ready"}, 64'(ir8), 64'd1);
    x8 = a; y8 = b; s8 = s; it8 = t; iv8 = 1'b1;
    @(negedge clk);
    iv8 = 1'b0;
    while (!ov8 && e < 30) begin @(negedge clk); e++; end
    check({name, "_lat"}, 64'(e), 64'd5);
    repeat (hold) @(negedge clk);
    check({name, "_prod"}, 64'(p8), 64'(exp));
    check({name, "_tag"}, 64'(ot8), 64'(t));
    $display("vec %s: x=0x%02h y=0x%02h s=%0d prod=0x%04h tag=%0h", name, a, b, s, p8, ot8);
    or8 = 1'b1;
    @(negedge clk);
    or8 = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [63:0] hold_prod;
    logic [3:0]  hold_tag;
    int          e;
    logic [31:0] r;

    repeat (3) @(negedge clk);
    check("rst_in_ready", 64'(ir32), 64'd1);
    check("rst_out_valid", 64'(ov32), 64'd0);
    check("rst_busy", 64'(busy32), 64'd0);
    check("rst_prod", p32, 64'd0);
    check("rst_tag", 64'(ot32), 64'd0);
    reset = 1'b1;
    @(negedge clk);

    send32(32'hFFFF_FFFD, 32'h0000_0005, 1'b1, 4'h6);
    recv32(64'hFFFF_FFFF_FFFF_FFF1, 4'h6, "neg3x5");
    send32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 4'h1);
    recv32(64'hFFFF_FFFE_0000_0001, 4'h1, "umax_sq");
    send32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 4'h2);
    recv32(64'h0000_0000_0000_0001, 4'h2, "sneg1_sq");
    send32(32'h8000_0000, 32'h8000_0000, 1'b1, 4'h3);
    recv32(64'h4000_0000_0000_0000, 4'h3, "smin_sq");
    send32(32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 4'h4);
    recv32(64'hC000_0000_8000_0000, 4'h4, "smin_smax");
    send32(32'h1234_5678, 32'h0000_0010, 1'b0, 4'hE);
    recv32(64'h0000_0001_2345_6780, 4'hE, "u_shift4");

    // Backpressure: result and tag must hold, in_valid pulses must be ignored
    send32(32'h0001_0000, 32'h0001_0000, 1'b0, 4'h7);
    wait_ov32(e);
    check("bp_lat", 64'(e), 64'd17);
    check("bp_prod", p32, 64'h0000_0001_0000_0000);
    hold_prod = p32;
    hold_tag  = ot32;
    for (int i = 0; i < 10; i++) begin
      r = $urandom;
      x32 = r; y32 = ~r; it32 = r[3:0]; iv32 = r[0];
      @(negedge clk);
      check("bp_hold_prod", p32, hold_prod);
      check("bp_hold_tag", 64'(ot32), 64'(hold_tag));
      check("bp_hold_ov", 64'(ov32), 64'd1);
      check("bp_hold_ir", 64'(ir32), 64'd0);
    end
    x32 = 32'h7FFF_FFFF; y32 = 32'h7FFF_FFFF; s32 = 1'b1; it32 = 4'h9;
    iv32 = 1'b1; or32 = 1'b1;
    @(negedge clk);
    or32 = 1'b0;
    check("bp_xfer_ov", 64'(ov32), 64'd0);
    check("bp_xfer_ir", 64'(ir32), 64'd1);
    @(negedge clk);
    iv32 = 1'b0;
    check("bp_accept_ir", 64'(ir32), 64'd0);
    check("bp_accept_busy", 64'(busy32), 64'd1);
    recv32(64'h3FFF_FFFF_0000_0001, 4'h9, "bp_next");

    // Reset during CALC discards the operation
    send32(32'h0000_1234, 32'h0000_5678, 1'b0, 4'h5);
    repeat (7) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("mid_rst_ov", 64'(ov32), 64'd0);
    check("mid_rst_prod", p32, 64'd0);
    check("mid_rst_ir", 64'(ir32), 64'd1);
    check("mid_rst_busy", 64'(busy32), 64'd0);
    check("mid_rst_tag", 64'(ot32), 64'd0);
    send32(32'd7, 32'd9, 1'b0, 4'hA);
    recv32(64'd63, 4'hA, "post_rst_7x9");

    // WIDTH=8: directed corners then a back-to-back stream with random stalls
    run8(8'h80, 8'h80, 1'b1, 4'h1, 16'h4000, 0, "w8_smin_sq");
    run8(8'hFF, 8'hFF, 1'b0, 4'h2, 16'hFE01, 2, "w8_umax_sq");
    run8(8'hFF, 8'h7F, 1'b1, 4'h3, 16'hFF81, 0, "w8_neg1_smax");
    run8(8'h80, 8'hFF, 1'b0, 4'h4, 16'h7F80, 1, "w8_u80_ff");
    for (int i = 0; i < 24; i++) begin
      logic [7:0] a, b;
      logic       s;
      r = $urandom;
      a = r[7:0]; b = r[15:8]; s = r[16];
      run8(a, b, s, 4'(i), model8(a, b, s), int'(r[18:17]), "w8_rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mul_booth_r4_seq.md
Name: mul_booth_r4_seq

Overview:
- Parametrised sequential radix-4 Booth multiplier for the NTT datapath (butterfly twiddle products, pre-reduction).
- Generalised successor of the fixed 32-bit Booth multiplier. Adds:
  - WIDTH parameter.
  - Per-operation signed/unsigned mode.
  - Valid/ready handshakes on input and output, with backpressure.
  - A tag carried through from input to output.
- Retires one Booth digit per cycle. Accepts a new operand pair only when idle.

Parameters:
- WIDTH, 32, operand width; must be even and >= 4.
- TAG_W, 4, width of the sideband tag passed through unchanged.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- in_valid  in  1  operand pair presented.
- in_ready  out  1  block can accept an operand pair.
- x  in  WIDTH  multiplicand.
- y  in  WIDTH  multiplier (Booth-recoded).
- is_signed  in  1  1 = both operands two's complement; 0 = both unsigned.
- in_tag  in  TAG_W  sideband tag.
- out_valid  out  1  product available.
- out_ready  in  1  consumer accepts the product.
- prod  out  2*WIDTH  product, two's complement if is_signed, otherwise unsigned.
- out_tag  out  TAG_W  tag captured with the operands.
- busy  out  1  high in CALC or DONE.

Behaviour:
- Constants:
  - N = WIDTH/2 + 1 Booth digits.
  - Internal operands are WIDTH+2 bits: sign-extended if is_signed, zero-extended otherwise. This makes unsigned full-range products exact.
- Reset (reset==0 at a clock edge):
  - State goes to IDLE.
  - in_ready=1, out_valid=0, busy=0, prod=0, out_tag=0.
  - Digit counter and accumulator are cleared.
  - Applies from any state; an in-flight operation is discarded with no output.
- FSM IDLE:
  - in_ready=1.
  - On in_valid at an edge: latch the extended x, y, is_signed and in_tag; clear accumulator and counter; go to CALC.
- FSM CALC:
  - in_ready=0.
  - Each edge processes digit i from triplet {y[2i+1], y[2i], y[2i-1]}, with y[-1]=0.
  - Digit values 0, +1, +2, -1, -2 select 0, X, 2X, -X, -2X.
  - The selected partial product is sign-extended to 2*WIDTH+4 bits, shifted left by 2i, and added to the accumulator (modular in the accumulator width).
  - After the edge that processes digit N-1, go to DONE.
- FSM DONE:
  - out_valid=1; prod = accumulator[2*WIDTH-1:0]; out_tag = latched tag.
  - Outputs are held stable while out_ready=0.
  - On out_ready at an edge: out_valid goes to 0 and state goes to IDLE.
  - There is no same-edge reload; a new operand is accepted at the earliest one edge later.
- Latency and throughput:
  - Operands accepted at edge k give out_valid visible after edge k+N (17 edges for WIDTH=32).
  - Minimum initiation interval is N+2 cycles.
- Negation (-X) is formed as ~X+1 in WIDTH+2 bits. X = most-negative value is handled correctly because of the 2 guard bits.
- Operand changes:
  - in_valid while not IDLE is ignored; the caller must hold in_valid until in_ready.
  - x, y, is_signed and in_tag are sampled only at the accept edge; later changes have no effect.
- No combinational path from in_valid or out_ready to any output except through registered state.
- No x/z assignments. All case statements have explicit defaults, which return the FSM to IDLE.

Decomposition:
- Package mul_booth_pkg holds:
  - The state enum (IDLE, CALC, DONE).
  - Booth digit encoding constants (ZERO, POS1, POS2, NEG1, NEG2).
  - The function for the digit count N.
- Sub-module booth_r4_enc: combinational; 3-bit triplet -> {neg, two, zero} select flags.
  - Instantiated once.
  - The partial-product mux and accumulator stay in the top module.

Test Plan:
- WIDTH=32, signed, x=-3 (0xFFFFFFFD), y=5 -> after 17 edges, prod=0xFFFFFFFFFFFFFFF1, out_tag equals the input tag.
- Unsigned, x=y=0xFFFFFFFF -> prod=0xFFFFFFFE00000001. The same operands signed -> prod=0x0000000000000001.
- Signed, x=y=0x80000000 -> prod=0x4000000000000000. Signed, x=0x80000000, y=0x7FFFFFFF -> prod=0xC000000080000000.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid. Check that prod, out_tag and out_valid stay stable, in_ready=0, and in_valid pulses are ignored. Then release: one transfer, and the next accept lands exactly 1 edge later.
- Reset mid-CALC (reset=0 at digit 7) -> next cycle state IDLE, out_valid=0, prod=0. A subsequent 7*9 completes with prod=63 and no stale result appears.
- Randomised back-to-back stream (WIDTH=8 and 32, mixed is_signed, random out_ready) versus a reference model. Check every product, tag order, and latency of exactly N edges from accept to out_valid.
